// File: rtl/amber_wb_pkg.sv
// Shared types and bus widths for the Amber 128-bit Wishbone memory responder.
package amber_wb_pkg;

  localparam int WB_DATA_W  = 128;
  localparam int WB_SEL_W   = 16;
  localparam int WB_ADR_W   = 32;
  localparam int LINE_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } wb_resp_state_t;

endpackage

// File: rtl/amber_wb_mem_responder_if.sv
// Wishbone classic-cycle bus bundle between the Amber core (master) and the memory responder (slave).
interface amber_wb_mem_responder_if;
  import amber_wb_pkg::*;

  logic [WB_ADR_W-1:0]  i_wb_adr;
  logic [WB_SEL_W-1:0]  i_wb_sel;
  logic                 i_wb_we;
  logic [WB_DATA_W-1:0] i_wb_dat;
  logic                 i_wb_cyc;
  logic                 i_wb_stb;
  logic [WB_DATA_W-1:0] o_wb_dat;
  logic                 o_wb_ack;
  logic                 o_wb_err;

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

endinterface

// File: rtl/amber_wb_line_ram.sv
// Line-organised memory: DEPTH x 128-bit lines, one byte-enabled write port, combinational read.
module amber_wb_line_ram
  import amber_wb_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [WB_SEL_W-1:0]  be,
  input  logic [IDX_W-1:0]     wr_index,
  input  logic [WB_DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_index,
  output logic [WB_DATA_W-1:0] rd_data
);

  logic [WB_DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset so preloaded programs survive a core reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (be[b]) mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_index];

endmodule

// File: rtl/amber_wb_mem_responder.sv
// Wishbone classic-cycle memory slave for the Amber 128-bit bus, with fixed wait states,
// out-of-range error termination and a preload port for filling instruction lines.
module amber_wb_mem_responder
  import amber_wb_pkg::*;
#(
  parameter  logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter  int                  DEPTH       = 256,
  parameter  int                  WAIT_STATES = 1,
  localparam int                  IDX_W       = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  amber_wb_mem_responder_if.slave  wb,
  input  logic                     i_ld_valid,
  input  logic [IDX_W-1:0]         i_ld_index,
  input  logic [WB_DATA_W-1:0]     i_ld_data,
  output logic                     o_ld_ready,
  output logic [15:0]              o_wr_count
);

  localparam logic [WB_ADR_W:0] SPAN      = (WB_ADR_W+1)'(longint'(DEPTH) * LINE_BYTES);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES);

  wb_resp_state_t       state_q, state_d;
  logic [3:0]           count_q, count_d;
  logic [WB_ADR_W-1:0]  adr_q;
  logic [WB_SEL_W-1:0]  sel_q;
  logic                 we_q;
  logic [WB_DATA_W-1:0] wdat_q;
  logic                 ack_q, err_q;
  logic [WB_DATA_W-1:0] rdat_q;
  logic [15:0]          wr_count_q;

  logic                 bus_req, enter_resp, out_of_range, bus_wr, ld_fire;
  logic [WB_ADR_W-1:0]  cur_adr, offset;
  logic [WB_ADR_W:0]    diff;
  logic [WB_SEL_W-1:0]  cur_sel;
  logic                 cur_we;
  logic [WB_DATA_W-1:0] cur_dat;
  logic [IDX_W-1:0]     line_index;

  logic                 ram_we;
  logic [WB_SEL_W-1:0]  ram_be;
  logic [IDX_W-1:0]     ram_wr_index;
  logic [WB_DATA_W-1:0] ram_wr_data, ram_rd_data;

  assign bus_req = wb.i_wb_cyc & wb.i_wb_stb;

  // With zero wait states RESP is entered on the capture edge, so decode must see the live bus.
  assign cur_adr = (state_q == ST_IDLE) ? wb.i_wb_adr : adr_q;
  assign cur_sel = (state_q == ST_IDLE) ? wb.i_wb_sel : sel_q;
  assign cur_we  = (state_q == ST_IDLE) ? wb.i_wb_we  : we_q;
  assign cur_dat = (state_q == ST_IDLE) ? wb.i_wb_dat : wdat_q;

  assign diff         = {1'b0, cur_adr} - {1'b0, BASE_ADDR};
  assign offset       = diff[WB_ADR_W-1:0];
  assign out_of_range = diff[WB_ADR_W] | ({1'b0, offset} >= SPAN);
  assign line_index   = offset[4 +: IDX_W];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_req) begin
          if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            count_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!bus_req) begin
          state_d = ST_IDLE;
          count_d = 4'd0;
        end else if (count_q == 4'd1) begin
          state_d    = ST_RESP;
          count_d    = 4'd0;
          enter_resp = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_wr     = enter_resp & cur_we & ~out_of_range;
  assign o_ld_ready = (state_q == ST_IDLE) & ~bus_req;
  assign ld_fire    = o_ld_ready & i_ld_valid;

  // Bus writes and preloads are mutually exclusive by construction of o_ld_ready.
  assign ram_we       = (bus_wr & ~i_rst) | ld_fire;
  assign ram_be       = bus_wr ? cur_sel    : '1;
  assign ram_wr_index = bus_wr ? line_index : i_ld_index;
  assign ram_wr_data  = bus_wr ? cur_dat    : i_ld_data;

  amber_wb_line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (i_clk),
    .we       (ram_we),
    .be       (ram_be),
    .wr_index (ram_wr_index),
    .wr_data  (ram_wr_data),
    .rd_index (line_index),
    .rd_data  (ram_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (state_q == ST_IDLE && bus_req) begin
      adr_q  <= wb.i_wb_adr;
      sel_q  <= wb.i_wb_sel;
      we_q   <= wb.i_wb_we;
      wdat_q <= wb.i_wb_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
      wr_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ack_q   <= enter_resp & ~out_of_range;
      err_q   <= enter_resp & out_of_range;
      rdat_q  <= (enter_resp & ~out_of_range & ~cur_we) ? ram_rd_data : '0;
      if (bus_wr && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_err = err_q;
  assign wb.o_wb_dat = rdat_q;
  assign o_wr_count  = wr_count_q;

endmodule

// File: tb/tb_amber_wb_mem_responder.sv
// Scoreboard bench: three responders (1, 0 and 3 wait states) driven by directed bus transactions.
module tb_amber_wb_mem_responder;
  import amber_wb_pkg::*;

  localparam int NL = 3;

  typedef struct {
    int           lane;
    bit           is_err;
    bit           chk_dat;
    logic [127:0] dat;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  logic         rst_d      [NL];
  logic [31:0]  adr_d      [NL];
  logic [15:0]  sel_d      [NL];
  logic         we_d       [NL];
  logic [127:0] dat_d      [NL];
  logic         wbcyc_d    [NL];
  logic         stb_d      [NL];
  logic         ld_valid_d [NL];
  logic [7:0]   ld_index_d [NL];
  logic [127:0] ld_data_d  [NL];

  logic         ack_w      [NL];
  logic         err_w      [NL];
  logic [127:0] dat_w      [NL];
  logic         ld_ready_w [NL];
  logic [15:0]  wr_w       [NL];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   mon_en   = 1'b0;

  function automatic int ws_of(input int lane);
    return (lane == 0) ? 1 : (lane == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : lane_g
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    amber_wb_mem_responder_if bus ();
    assign bus.i_wb_adr = adr_d[g];
    assign bus.i_wb_sel = sel_d[g];
    assign bus.i_wb_we  = we_d[g];
    assign bus.i_wb_dat = dat_d[g];
    assign bus.i_wb_cyc = wbcyc_d[g];
    assign bus.i_wb_stb = stb_d[g];
    assign ack_w[g]     = bus.o_wb_ack;
    assign err_w[g]     = bus.o_wb_err;
    assign dat_w[g]     = bus.o_wb_dat;

    amber_wb_mem_responder #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH       (256),
      .WAIT_STATES (WS)
    ) dut (
      .i_clk      (clk),
      .i_rst      (rst_d[g]),
      .wb         (bus.slave),
      .i_ld_valid (ld_valid_d[g]),
      .i_ld_index (ld_index_d[g]),
      .i_ld_data  (ld_data_d[g]),
      .o_ld_ready (ld_ready_w[g]),
      .o_wr_count (wr_w[g])
    );
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: every response pops the scoreboard; data must be zero whenever ack is low.
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < NL; l++) begin
        if (ack_w[l] | err_w[l]) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL unexpected_resp lane %0d: actual ack=%0b err=%0b required none", l, ack_w[l], err_w[l]);
          end else begin
            e = exp_q.pop_front();
            check_output("resp_lane",  128'(l),         128'(e.lane));
            check_output("resp_cycle", 128'(cycle_no),  128'(e.cyc));
            check_output("resp_err",   128'(err_w[l]),  128'(e.is_err));
            check_output("resp_ack",   128'(ack_w[l]),  128'(!e.is_err));
            if (e.chk_dat) check_output("resp_dat", dat_w[l], e.dat);
          end
        end
        if (!ack_w[l]) check_output("dat_zero_no_ack", dat_w[l], 128'd0);
      end
    end
  end

  task automatic wait_resp(input int lane);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_w[lane] | err_w[lane]) seen = 1'b1;
    end
    check_output("resp_within_budget", 128'(seen), 128'd1);
  endtask

  task automatic preload_line(input int lane, input logic [7:0] idx, input logic [127:0] data);
    @(negedge clk);
    ld_valid_d[lane] = 1'b1;
    ld_index_d[lane] = idx;
    ld_data_d[lane]  = data;
    #1 check_output("ld_ready_idle", 128'(ld_ready_w[lane]), 128'd1);
    @(posedge clk);
    #1 ld_valid_d[lane] = 1'b0;
  endtask

  // One complete master cycle; optionally collides a preload with the request.
  task automatic apply_stimulus(input int lane, input logic [31:0] adr, input logic [15:0] sel,
                                input logic we, input logic [127:0] dat, input bit exp_err,
                                input logic [127:0] exp_dat, input bit collide,
                                input logic [7:0] ld_idx, input logic [127:0] ld_dat);
    exp_t x;
    @(negedge clk);
    adr_d[lane] = adr; sel_d[lane] = sel; we_d[lane] = we; dat_d[lane] = dat;
    wbcyc_d[lane] = 1'b1; stb_d[lane] = 1'b1;
    x.lane    = lane;
    x.is_err  = exp_err;
    x.chk_dat = exp_err | !we;
    x.dat     = exp_err ? 128'd0 : exp_dat;
    x.cyc     = cycle_no + 1 + ws_of(lane);
    exp_q.push_back(x);
    if (collide) begin
      ld_valid_d[lane] = 1'b1; ld_index_d[lane] = ld_idx; ld_data_d[lane] = ld_dat;
      #1 check_output("ld_ready_collide", 128'(ld_ready_w[lane]), 128'd0);
      @(posedge clk);
      #1 ld_valid_d[lane] = 1'b0;
    end
    wait_resp(lane);
    wbcyc_d[lane] = 1'b0; stb_d[lane] = 1'b0;
  endtask

  localparam logic [127:0] P0   = 128'h1111_2222_3333_4444_5555_6666_F080_1003;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] P255 = 128'hCAFE_0255_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] R3   = 128'h3333_AAAA_3333_AAAA_3333_AAAA_3333_AAAA;
  localparam logic [127:0] Q3   = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
  localparam logic [127:0] PA   = 128'h0BAD_F00D_1234_5678_9ABC_DEF0_0F0F_0F0F;
  localparam logic [127:0] WX   = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_DEAD_BEEF;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int l = 0; l < NL; l++) begin
      rst_d[l] = 1'b1; adr_d[l] = '0; sel_d[l] = '0; we_d[l] = 1'b0; dat_d[l] = '0;
      wbcyc_d[l] = 1'b0; stb_d[l] = 1'b0;
      ld_valid_d[l] = 1'b0; ld_index_d[l] = '0; ld_data_d[l] = '0;
    end
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) begin
      check_output("reset_ack",      128'(ack_w[l]),      128'd0);
      check_output("reset_err",      128'(err_w[l]),      128'd0);
      check_output("reset_dat",      dat_w[l],            128'd0);
      check_output("reset_wr_count", 128'(wr_w[l]),       128'd0);
      check_output("reset_ld_ready", 128'(ld_ready_w[l]), 128'd1);
      rst_d[l] = 1'b0;
    end
    mon_en = 1'b1;

    // Lane 0, one wait state: preload/read, masked write, range errors, last line, collision.
    preload_line(0, 8'd0, P0);
    apply_stimulus(0, 32'h0000_0000, 16'hFFFF, 1'b0, '0, 1'b0, P0, 1'b0, '0, '0);
    preload_line(0, 8'd1, ONES);
    apply_stimulus(0, 32'h0000_0010, 16'h000F, 1'b1, WX, 1'b0, '0, 1'b0, '0, '0);
    apply_stimulus(0, 32'h0000_0010, 16'h0000, 1'b0, '0, 1'b0,
                   {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF}, 1'b0, '0, '0);
    check_output("wr_count_after_write", 128'(wr_w[0]), 128'd1);
    apply_stimulus(0, 32'h0000_1000, 16'hFFFF, 1'b0, '0, 1'b1, '0, 1'b0, '0, '0);
    apply_stimulus(0, 32'h0000_1000, 16'hFFFF, 1'b1, ONES, 1'b1, '0, 1'b0, '0, '0);
    check_output("wr_count_after_err", 128'(wr_w[0]), 128'd1);
    preload_line(0, 8'd255, P255);
    apply_stimulus(0, 32'h0000_0FFC, 16'hFFFF, 1'b0, '0, 1'b0, P255, 1'b0, '0, '0);
    apply_stimulus(0, 32'h0000_001C, 16'hF000, 1'b1, {32'h1234_5678, 96'd0}, 1'b0, '0, 1'b0, '0, '0);
    apply_stimulus(0, 32'h0000_0018, 16'hFFFF, 1'b0, '0, 1'b0,
                   {32'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF}, 1'b0, '0, '0);
    check_output("wr_count_two_writes", 128'(wr_w[0]), 128'd2);
    preload_line(0, 8'd3, R3);
    apply_stimulus(0, 32'h0000_0030, 16'hFFFF, 1'b0, '0, 1'b0, R3, 1'b1, 8'd3, Q3);
    apply_stimulus(0, 32'h0000_0030, 16'hFFFF, 1'b0, '0, 1'b0, R3, 1'b0, '0, '0);

    // Lane 1, zero wait states: strobe held across three reads completes every other cycle.
    preload_line(1, 8'd0, P0);
    begin
      exp_t x;
      int got = 0;
      @(negedge clk);
      adr_d[1] = 32'h0; sel_d[1] = 16'hFFFF; we_d[1] = 1'b0;
      wbcyc_d[1] = 1'b1; stb_d[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        x.lane = 1; x.is_err = 1'b0; x.chk_dat = 1'b1; x.dat = P0;
        x.cyc = cycle_no + 1 + 2 * k;
        exp_q.push_back(x);
      end
      for (int i = 0; i < 20 && got < 3; i++) begin
        @(negedge clk);
        if (ack_w[1]) got++;
      end
      wbcyc_d[1] = 1'b0; stb_d[1] = 1'b0;
      check_output("held_stb_ack_count", 128'(got), 128'd3);
    end

    // Lane 2, three wait states: strobe drop and reset during WAIT must both drop the write.
    preload_line(2, 8'd2, PA);
    @(negedge clk);
    adr_d[2] = 32'h0000_0020; sel_d[2] = 16'hFFFF; we_d[2] = 1'b1; dat_d[2] = ONES;
    wbcyc_d[2] = 1'b1; stb_d[2] = 1'b1;
    repeat (2) @(negedge clk);
    stb_d[2] = 1'b0;
    repeat (6) @(negedge clk);
    wbcyc_d[2] = 1'b0;
    apply_stimulus(2, 32'h0000_0020, 16'hFFFF, 1'b0, '0, 1'b0, PA, 1'b0, '0, '0);
    check_output("wr_count_after_abort", 128'(wr_w[2]), 128'd0);

    @(negedge clk);
    adr_d[2] = 32'h0000_0020; sel_d[2] = 16'hFFFF; we_d[2] = 1'b1; dat_d[2] = ONES;
    wbcyc_d[2] = 1'b1; stb_d[2] = 1'b1;
    repeat (3) @(negedge clk);
    rst_d[2] = 1'b1;
    @(negedge clk);
    rst_d[2] = 1'b0; wbcyc_d[2] = 1'b0; stb_d[2] = 1'b0;
    #1 check_output("ld_ready_after_reset", 128'(ld_ready_w[2]), 128'd1);
    repeat (3) @(negedge clk);
    apply_stimulus(2, 32'h0000_0020, 16'hFFFF, 1'b0, '0, 1'b0, PA, 1'b0, '0, '0);
    check_output("wr_count_after_reset", 128'(wr_w[2]), 128'd0);
    apply_stimulus(2, 32'h0000_0024, 16'h00FF, 1'b1, ONES, 1'b0, '0, 1'b0, '0, '0);
    apply_stimulus(2, 32'h0000_0020, 16'hFFFF, 1'b0, '0, 1'b0,
                   {PA[127:64], 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, '0, '0);
    check_output("wr_count_lane2", 128'(wr_w[2]), 128'd1);

    repeat (5) @(negedge clk);
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
